// File: rtl/cnn_ot_bias_act.sv
// cnn_ot_bias_act: bias add, optional ReLU, rounding requantization, saturation and CO-channel packing.
// Build option: define CNN_RELU_EN for ReLU with unsigned outputs; default build gives signed outputs.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   i_soft_reset synchronous clear of all state, overrides every other input
//   i_bias       CO signed biases, channel c at [c*B_BW +: B_BW]
//   i_shift      rounding right-shift amount, 0..ACI_BW
//   i_in_valid   i_in_ci_acc valid this cycle (channels arrive in order 0..CO-1)
//   i_in_ci_acc  signed accumulated sum
//   o_ot_valid   one-cycle pulse when o_ot_fmap holds a complete pixel
//   o_ot_fmap    packed results, channel c at [c*O_F_BW +: O_F_BW]
module cnn_ot_bias_act #(
    parameter int CO     = 4,
    parameter int ACI_BW = 24,
    parameter int B_BW   = 16,
    parameter int O_F_BW = 8,
    parameter int SH_BW  = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_soft_reset,
    input  logic [CO*B_BW-1:0]     i_bias,
    input  logic [SH_BW-1:0]       i_shift,
    input  logic                   i_in_valid,
    input  logic [ACI_BW-1:0]      i_in_ci_acc,
    output logic                   o_ot_valid,
    output logic [CO*O_F_BW-1:0]   o_ot_fmap
);
    localparam int CW = (CO > 1) ? $clog2(CO) : 1;
    localparam int VW = ACI_BW + 2;
`ifdef CNN_RELU_EN
    localparam logic signed [VW-1:0] V_MAX = VW'((1 << O_F_BW) - 1);
    localparam logic signed [VW-1:0] V_MIN = '0;
`else
    localparam logic signed [VW-1:0] V_MAX = VW'((1 << (O_F_BW - 1)) - 1);
    localparam logic signed [VW-1:0] V_MIN = VW'(-(1 << (O_F_BW - 1)));
`endif
    localparam logic [CW-1:0] LAST = CW'(CO - 1);
    logic [CW-1:0]            ch_cnt, s1_tag, s2_tag;
    logic                     s1_valid, s2_valid;
    logic [B_BW-1:0]          bias;
    logic signed [ACI_BW:0]   sum, s1_sum;
    logic [SH_BW-1:0]         s1_shift;
    logic signed [VW-1:0]     v, rnd, shd;
    logic [O_F_BW-1:0]        res, s2_res;
    logic [CO*O_F_BW-1:0]     slots, word;
    // Stage 1 operands: bias of the channel this input is tagged with.
    always_comb begin
        bias = i_bias[ch_cnt*B_BW +: B_BW];
        sum  = $signed({i_in_ci_acc[ACI_BW-1], i_in_ci_acc})
             + $signed({{(ACI_BW+1-B_BW){bias[B_BW-1]}}, bias});
    end
    // Stage 2: the shift amount travels with the sum so a change only affects later inputs.
    // A zero shift gives a zero rounding term, so the value passes through unchanged.
    always_comb begin
        v = $signed({s1_sum[ACI_BW], s1_sum});
`ifdef CNN_RELU_EN
        if (s1_sum[ACI_BW]) v = '0;
`endif
        rnd = (s1_shift == '0) ? '0 : $signed({{(VW-1){1'b0}}, 1'b1} << (s1_shift - 1'b1));
        shd = (v + rnd) >>> s1_shift;
        res = (shd > V_MAX) ? V_MAX[O_F_BW-1:0] : (shd < V_MIN) ? V_MIN[O_F_BW-1:0] : shd[O_F_BW-1:0];
    end
    // Stage 3: current slots with the arriving element merged in, so the last channel lands in the same cycle.
    always_comb begin
        word = slots;
        word[s2_tag*O_F_BW +: O_F_BW] = s2_res;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_cnt     <= '0;
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_sum     <= '0;
            s1_shift   <= '0;
            s2_valid   <= 1'b0;
            s2_tag     <= '0;
            s2_res     <= '0;
            slots      <= '0;
            o_ot_valid <= 1'b0;
            o_ot_fmap  <= '0;
        end else if (i_soft_reset) begin
            ch_cnt     <= '0;
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            s1_sum     <= '0;
            s1_shift   <= '0;
            s2_valid   <= 1'b0;
            s2_tag     <= '0;
            s2_res     <= '0;
            slots      <= '0;
            o_ot_valid <= 1'b0;
            o_ot_fmap  <= '0;
        end else begin
            if (i_in_valid) begin
                ch_cnt   <= (ch_cnt == LAST) ? '0 : ch_cnt + 1'b1;
                s1_tag   <= ch_cnt;
                s1_sum   <= sum;
                s1_shift <= i_shift;
            end
            s1_valid <= i_in_valid;
            if (s1_valid) begin
                s2_tag <= s1_tag;
                s2_res <= res;
            end
            s2_valid <= s1_valid;
            if (s2_valid) slots <= word;
            o_ot_valid <= s2_valid && (s2_tag == LAST);
            if (s2_valid && (s2_tag == LAST)) o_ot_fmap <= word;
        end
    end
endmodule

// File: tb/tb_cnn_ot_bias_act.sv
// tb_cnn_ot_bias_act: directed and randomized checks of cnn_ot_bias_act against an arithmetic reference model.
module tb_cnn_ot_bias_act;
    localparam int CO = 4, ACI_BW = 24, B_BW = 16, O_F_BW = 8, SH_BW = 5;
    localparam int FW = CO * O_F_BW;
`ifdef CNN_RELU_EN
    localparam logic [FW-1:0] EXP_RELU = 32'h0000_0000;
    localparam logic [FW-1:0] EXP_SAT  = 32'h0000_00FF;
`else
    localparam logic [FW-1:0] EXP_RELU = 32'h0000_00F9;
    localparam logic [FW-1:0] EXP_SAT  = 32'h0000_807F;
`endif
    logic clk = 1'b0, reset_n = 1'b0, i_soft_reset = 1'b0, i_in_valid = 1'b0;
    logic [CO*B_BW-1:0] i_bias = '0;
    logic [SH_BW-1:0] i_shift = '0;
    logic [ACI_BW-1:0] i_in_ci_acc = '0;
    logic o_ot_valid;
    logic [FW-1:0] o_ot_fmap;
    int checks = 0, failures = 0, cyc = 0, pulses = 0, m_ch = 0, p0 = 0;
    logic [FW-1:0] m_word = '0, last = '0;
    logic [FW-1:0] exp_q[$];
    int due_q[$];
    bit mon_on = 1'b0;

    cnn_ot_bias_act #(.CO(CO), .ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW), .SH_BW(SH_BW)) dut (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset), .i_bias(i_bias), .i_shift(i_shift),
        .i_in_valid(i_in_valid), .i_in_ci_acc(i_in_ci_acc), .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Element value straight from the arithmetic rules: add, clip negatives, round half up, clamp.
    function automatic logic [O_F_BW-1:0] ref_elem(input longint acc, input longint b, input int sh);
        longint v, lo, hi;
        v = acc + b;
`ifdef CNN_RELU_EN
        if (v < 0) v = 0;
        lo = 0;
        hi = (longint'(1) << O_F_BW) - 1;
`else
        lo = -(longint'(1) << (O_F_BW - 1));
        hi = (longint'(1) << (O_F_BW - 1)) - 1;
`endif
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[O_F_BW-1:0];
    endfunction

    task automatic flush();
        exp_q.delete();
        due_q.delete();
        m_ch = 0;
        m_word = '0;
        last = '0;
    endtask

    // Model: an input taken at this edge shows up as a pixel pulse in the third cycle after its input cycle.
    always @(posedge clk) begin
        cyc++;
        if (!reset_n || i_soft_reset) flush();
        else if (i_in_valid) begin
            m_word[m_ch*O_F_BW +: O_F_BW] = ref_elem(longint'($signed(i_in_ci_acc)),
                longint'($signed(i_bias[m_ch*B_BW +: B_BW])), int'(i_shift));
            if (m_ch == CO - 1) begin
                exp_q.push_back(m_word);
                due_q.push_back(cyc + 2);
                m_ch = 0;
            end else m_ch++;
        end
    end

    always @(negedge clk) if (mon_on) begin
        bit d;
        d = (due_q.size() > 0) && (due_q[0] == cyc);
        check("valid", 64'(o_ot_valid), 64'(d));
        if (o_ot_valid) pulses++;
        if (d) begin
            last = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        check("fmap", 64'(o_ot_fmap), 64'(last));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int a);
        i_in_valid = 1'b1;
        i_in_ci_acc = ACI_BW'(a);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send_px(input int a0, input int a1, input int a2, input int a3);
        send(a0);
        send(a1);
        send(a2);
        send(a3);
        idle(5);
    endtask

    initial begin
        idle(2);
        check("rst_valid", 64'(o_ot_valid), 64'd0);
        check("rst_fmap", 64'(o_ot_fmap), 64'd0);
        reset_n = 1'b1;
        mon_on = 1'b1;
        idle(2);
        p0 = pulses;
        send_px(5, 6, 7, 8);
        check("pack", 64'(o_ot_fmap), 64'h0807_0605);
        check("pack_pulses", 64'(pulses - p0), 64'd1);
        i_bias[B_BW-1:0] = B_BW'(-10);
        send_px(3, 0, 0, 0);
        check("relu", 64'(o_ot_fmap), 64'(EXP_RELU));
        i_bias = '0;
        i_shift = SH_BW'(2);
        send_px(6, 5, 2, 1);
        check("round", 64'(o_ot_fmap), 64'h0001_0102);
        i_shift = '0;
        send_px(1000, -1000, 0, 0);
        check("sat", 64'(o_ot_fmap), 64'(EXP_SAT));
        send(11);
        send(12);
        i_soft_reset = 1'b1;
        i_in_valid = 1'b1;
        i_in_ci_acc = ACI_BW'(77);
        @(posedge clk);
        #1;
        i_soft_reset = 1'b0;
        i_in_valid = 1'b0;
        check("soft_fmap", 64'(o_ot_fmap), 64'd0);
        p0 = pulses;
        for (int k = 1; k <= 4; k++) begin
            idle($urandom_range(0, 3));
            send(k);
        end
        idle(5);
        check("gap_fmap", 64'(o_ot_fmap), 64'h0403_0201);
        check("gap_pulses", 64'(pulses - p0), 64'd1);
        send(1);
        send(2);
        send(3);
        reset_n = 1'b0;
        flush();
        #1;
        check("arst_valid", 64'(o_ot_valid), 64'd0);
        check("arst_fmap", 64'(o_ot_fmap), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        send_px(9, 9, 9, 9);
        check("arst_pixel", 64'(o_ot_fmap), 64'h0909_0909);
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int c = 0; c < CO; c++) i_bias[c*B_BW +: B_BW] = B_BW'($urandom);
                i_shift = SH_BW'($urandom_range(0, ACI_BW));
            end
            for (int c = 0; c < CO; c++) begin
                if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 2));
                if ($urandom_range(0, 1) == 1) send(int'($urandom_range(0, 4000)) - 2000);
                else send(int'($urandom));
            end
        end
        idle(6);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
